// File: rtl/rpsc_pkg.sv
// Shared definitions for the RPSC power-on sequencer and future rack diagnostics.
package rpsc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_G2_START  = 3'd1,
      ST_DRV_START = 3'd2,
      ST_AN_START  = 3'd3,
      ST_RUN       = 3'd4,
      ST_SHUTDOWN  = 3'd5,
      ST_FAULT     = 3'd6
   } seq_state_t;

   typedef enum logic [2:0] {
      FC_NONE        = 3'd0,
      FC_PERM_AN     = 3'd1,
      FC_PERM_DRV    = 3'd2,
      FC_G2_TIMEOUT  = 3'd3,
      FC_G2_LOST     = 3'd4,
      FC_U_G2_LOW    = 3'd5,
      FC_DRV_TIMEOUT = 3'd6,
      FC_DRV_LOST    = 3'd7
   } fault_code_t;

   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/rpsc_on_sequencer_if.sv
// Card-3 status inputs, operator pulses and supply commands of the RPSC sequencer.
interface rpsc_on_sequencer_if;
   // No valid/ready pairs here: every input is a level sampled on each clock edge,
   // and every output is a registered level that is valid in every cycle.
   logic       on_req;
   logic       off_req;
   logic       fault_ack;
   logic       n_on_perm_an;
   logic       n_on_perm_drv;
   logic       n_g2_ok;
   logic       n_u_g2_low;
   logic       n_dr_amp_ok;
   logic       g2_ps_cmd;
   logic       dr_amp_cmd;
   logic       an_ps_cmd;
   logic       running;
   logic       perm_denied;
   logic       fault_latched;
   logic [2:0] fault_code;
   logic [2:0] state_o;

   modport master (
      output on_req, off_req, fault_ack,
      output n_on_perm_an, n_on_perm_drv, n_g2_ok, n_u_g2_low, n_dr_amp_ok,
      input  g2_ps_cmd, dr_amp_cmd, an_ps_cmd, running, perm_denied,
      input  fault_latched, fault_code, state_o
   );

   modport slave (
      input  on_req, off_req, fault_ack,
      input  n_on_perm_an, n_on_perm_drv, n_g2_ok, n_u_g2_low, n_dr_amp_ok,
      output g2_ps_cmd, dr_amp_cmd, an_ps_cmd, running, perm_denied,
      output fault_latched, fault_code, state_o
   );
endinterface

// File: rtl/rpsc_cycle_timer.sv
// Up-counter with synchronous clear/load and a terminal-count compare against tc_value.
module rpsc_cycle_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic [W-1:0] tc_value,
   output logic         tc
);
   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) count <= '0;
      else if (load)      count <= load_value;
      else                count <= count + 1'b1;
   end

   assign tc = (count == tc_value);
endmodule

// File: rtl/rpsc_on_sequencer.sv
// Orders G2, driver amp and anode supply on-commands; drops all and latches the
// first fault cause on any interlock loss until an acknowledged, permitted reset.
module rpsc_on_sequencer
   import rpsc_pkg::*;
#(
   parameter int G2_TIMEOUT  = 320,
   parameter int DRV_TIMEOUT = 128,
   parameter int AN_SETTLE   = 64,
   parameter int OFF_GAP     = 32
) (
   input logic           clk,
   input logic           reset,
   rpsc_on_sequencer_if.slave bus
);
   localparam int TW = $clog2(max_of4(G2_TIMEOUT, DRV_TIMEOUT, AN_SETTLE, OFF_GAP)) + 1;

   seq_state_t    state, next_state;
   fault_code_t   code, next_code, cause;
   logic          sd_step, next_sd_step;
   logic          permits_ok, monitored, past_g2, past_drv;
   logic          deny, tmr_clear, tmr_tc;
   logic [TW-1:0] tmr_limit;
   logic          g2_cmd, dr_cmd, an_cmd, run_flag, deny_q, fault_flag;

   rpsc_cycle_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .clear      (tmr_clear),
      .load       (1'b0),
      .load_value ('0),
      .tc_value   (tmr_limit),
      .tc         (tmr_tc)
   );

   assign permits_ok = !bus.n_on_perm_an && !bus.n_on_perm_drv;
   assign monitored  = state inside {ST_G2_START, ST_DRV_START, ST_AN_START, ST_RUN};
   assign past_g2    = state inside {ST_DRV_START, ST_AN_START, ST_RUN};
   assign past_drv   = state inside {ST_AN_START, ST_RUN};

   always_comb begin
      tmr_limit = '0;
      case (state)
         ST_G2_START:  tmr_limit = TW'(G2_TIMEOUT - 1);
         ST_DRV_START: tmr_limit = TW'(DRV_TIMEOUT - 1);
         ST_AN_START:  tmr_limit = TW'(AN_SETTLE - 1);
         ST_SHUTDOWN:  tmr_limit = TW'(OFF_GAP - 1);
         default:      tmr_limit = '0;
      endcase
   end

   // Priority chain yields the lowest code when several causes coincide; a timeout
   // only counts while its exit condition is still unmet.
   always_comb begin
      cause = FC_NONE;
      if (monitored) begin
         if (bus.n_on_perm_an)                                   cause = FC_PERM_AN;
         else if (bus.n_on_perm_drv)                             cause = FC_PERM_DRV;
         else if (state == ST_G2_START && tmr_tc && bus.n_g2_ok) cause = FC_G2_TIMEOUT;
         else if (past_g2 && bus.n_g2_ok)                        cause = FC_G2_LOST;
         else if (past_g2 && !bus.n_u_g2_low)                    cause = FC_U_G2_LOW;
         else if (state == ST_DRV_START && tmr_tc && bus.n_dr_amp_ok) cause = FC_DRV_TIMEOUT;
         else if (past_drv && bus.n_dr_amp_ok)                   cause = FC_DRV_LOST;
      end
   end

   always_comb begin
      next_state   = state;
      next_code    = code;
      next_sd_step = sd_step;
      deny         = 1'b0;
      tmr_clear    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.on_req) begin
               if (permits_ok) next_state = ST_G2_START;
               else            deny = 1'b1;
            end
         end
         ST_G2_START: begin
            if (bus.off_req)      next_state = ST_SHUTDOWN;
            else if (!bus.n_g2_ok) next_state = ST_DRV_START;
         end
         ST_DRV_START: begin
            if (bus.off_req)          next_state = ST_SHUTDOWN;
            else if (!bus.n_dr_amp_ok) next_state = ST_AN_START;
         end
         ST_AN_START: begin
            if (bus.off_req) next_state = ST_SHUTDOWN;
            else if (tmr_tc) next_state = ST_RUN;
         end
         ST_RUN: begin
            if (bus.off_req) next_state = ST_SHUTDOWN;
         end
         ST_SHUTDOWN: begin
            if (tmr_tc) begin
               if (!sd_step) next_sd_step = 1'b1;
               else          next_state = ST_IDLE;
            end
         end
         ST_FAULT: begin
            if (bus.fault_ack && permits_ok) begin
               next_state = ST_IDLE;
               next_code  = FC_NONE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
      if (cause != FC_NONE) begin
         next_state = ST_FAULT;
         next_code  = cause;
      end
      if (next_state == ST_SHUTDOWN && state != ST_SHUTDOWN) next_sd_step = 1'b0;
      tmr_clear = (next_state != state) || (next_sd_step != sd_step);
   end

   // Outputs are decoded from the next state so they move on the transition edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         code       <= FC_NONE;
         sd_step    <= 1'b0;
         g2_cmd     <= 1'b0;
         dr_cmd     <= 1'b0;
         an_cmd     <= 1'b0;
         run_flag   <= 1'b0;
         deny_q     <= 1'b0;
         fault_flag <= 1'b0;
      end else begin
         state      <= next_state;
         code       <= next_code;
         sd_step    <= next_sd_step;
         run_flag   <= (next_state == ST_RUN);
         fault_flag <= (next_state == ST_FAULT);
         deny_q     <= deny;
         if (next_state == ST_SHUTDOWN) begin
            g2_cmd <= g2_cmd;
            dr_cmd <= dr_cmd && !next_sd_step;
            an_cmd <= 1'b0;
         end else begin
            g2_cmd <= next_state inside {ST_G2_START, ST_DRV_START, ST_AN_START, ST_RUN};
            dr_cmd <= next_state inside {ST_DRV_START, ST_AN_START, ST_RUN};
            an_cmd <= next_state inside {ST_AN_START, ST_RUN};
         end
      end
   end

   assign bus.g2_ps_cmd     = g2_cmd;
   assign bus.dr_amp_cmd    = dr_cmd;
   assign bus.an_ps_cmd     = an_cmd;
   assign bus.running       = run_flag;
   assign bus.perm_denied   = deny_q;
   assign bus.fault_latched = fault_flag;
   assign bus.fault_code    = code;
   assign bus.state_o       = state;
endmodule

// File: tb/tb_rpsc_on_sequencer.sv
// Randomised bench for rpsc_on_sequencer: expected output events are timed from the
// sequencing rules and matched against every observed output change.
module tb_rpsc_on_sequencer;
   import rpsc_pkg::*;

   localparam int T_G2   = 320;
   localparam int T_DRV  = 128;
   localparam int T_SET  = 64;
   localparam int T_GAP  = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   logic [12:0] exp_q[$];
   int          exp_t[$];
   logic        mon_en = 1'b0;
   logic [12:0] prev;

   rpsc_on_sequencer_if bus ();

   rpsc_on_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog cycle=%0d required=finish before time limit", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic logic [12:0] pack();
      return {bus.g2_ps_cmd, bus.dr_amp_cmd, bus.an_ps_cmd, bus.running,
              bus.perm_denied, bus.fault_latched, bus.fault_code, bus.state_o};
   endfunction

   function automatic logic [12:0] mk(input logic g2, input logic dr, input logic an,
                                      input logic run, input logic pd, input logic fl,
                                      input logic [2:0] fc, input seq_state_t st);
      return {g2, dr, an, run, pd, fl, fc, st};
   endfunction

   task automatic push(input int t, input logic [12:0] v);
      exp_t.push_back(t);
      exp_q.push_back(v);
   endtask

   task automatic check(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s got=%0d required=%0d", name, got, req);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      bus.on_req        = 1'b0;
      bus.off_req       = 1'b0;
      bus.fault_ack     = 1'b0;
      bus.n_on_perm_an  = 1'b0;
      bus.n_on_perm_drv = 1'b0;
      bus.n_g2_ok       = 1'b1;
      bus.n_u_g2_low    = 1'b1;
      bus.n_dr_amp_ok   = 1'b1;
   endtask

   task automatic at(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // which: 0 on_req, 1 off_req, 2 fault_ack
   task automatic pulse(input int which);
      case (which)
         0: bus.on_req = 1'b1;
         1: bus.off_req = 1'b1;
         default: bus.fault_ack = 1'b1;
      endcase
      @(negedge clk);
      bus.on_req    = 1'b0;
      bus.off_req   = 1'b0;
      bus.fault_ack = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout now=%0d pending=%0d next_required=%h@%0d",
                  cyc, exp_q.size(), exp_q[0], exp_t[0]);
         exp_q.delete();
         exp_t.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   // lvl: 1 G2_START, 2 DRV_START, 3 AN_START, 4 RUN. d1/d2: cycles from entry to exit.
   task automatic run_to(input int lvl, input int d1, input int d2, output int e);
      e = cyc + 1;
      push(e, mk(1, 0, 0, 0, 0, 0, 3'd0, ST_G2_START));
      pulse(0);
      if (lvl >= 2) begin
         at(e + d1 - 1);
         bus.n_g2_ok = 1'b0;
         e = e + d1;
         push(e, mk(1, 1, 0, 0, 0, 0, 3'd0, ST_DRV_START));
      end
      if (lvl >= 3) begin
         at(e + d2 - 1);
         bus.n_dr_amp_ok = 1'b0;
         e = e + d2;
         push(e, mk(1, 1, 1, 0, 0, 0, 3'd0, ST_AN_START));
      end
      if (lvl >= 4) begin
         e = e + T_SET;
         push(e, mk(1, 1, 1, 1, 0, 0, 3'd0, ST_RUN));
      end
   endtask

   task automatic shutdown(input int lvl);
      int c;
      logic dr_on;
      c = cyc;
      dr_on = (lvl >= 2);
      push(c + 1, mk(1, dr_on, 0, 0, 0, 0, 3'd0, ST_SHUTDOWN));
      if (dr_on) push(c + 1 + T_GAP, mk(1, 0, 0, 0, 0, 0, 3'd0, ST_SHUTDOWN));
      push(c + 1 + 2 * T_GAP, mk(0, 0, 0, 0, 0, 0, 3'd0, ST_IDLE));
      pulse(1);
      // interlock losses during the ramp-down must not divert it
      bus.n_g2_ok      = 1'b1;
      bus.n_dr_amp_ok  = 1'b1;
      bus.n_on_perm_an = 1'b1;
      at(c + 40);
      bus.n_on_perm_an = 1'b0;
      drain(200);
   endtask

   task automatic recover();
      idle_inputs();
      push(cyc + 1, mk(0, 0, 0, 0, 0, 0, 3'd0, ST_IDLE));
      pulse(2);
      drain(50);
   endtask

   task automatic fault_case(input int lvl, input int k, input logic [4:0] m);
      int e, c, code;
      run_to(lvl, $urandom_range(1, T_G2), $urandom_range(1, T_DRV), e);
      at(e + k);
      code = 0;
      if (m[0])                   code = 1;
      else if (m[1])              code = 2;
      else if (m[2] && lvl >= 2)  code = 4;
      else if (m[3] && lvl >= 2)  code = 5;
      else if (m[4] && lvl >= 3)  code = 7;
      if (m[0]) bus.n_on_perm_an  = 1'b1;
      if (m[1]) bus.n_on_perm_drv = 1'b1;
      if (m[2]) bus.n_g2_ok       = 1'b1;
      if (m[3]) bus.n_u_g2_low    = 1'b0;
      if (m[4]) bus.n_dr_amp_ok   = 1'b1;
      c = cyc;
      if (code == 0) begin
         repeat (5) @(negedge clk);
         bus.n_on_perm_drv = 1'b1;
         code = 2;
         c = cyc;
      end
      push(c + 1, mk(0, 0, 0, 0, 0, 1, 3'(code), ST_FAULT));
      drain(100);
      recover();
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [12:0] cur, ev;
      int t;
      if (mon_en) begin
         cur = pack();
         if (cur !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change cycle=%0d got=%h required=no change from %h",
                        cyc, cur, prev);
            end else begin
               ev = exp_q.pop_front();
               t  = exp_t.pop_front();
               if (cur !== ev || cyc != t) begin
                  errors++;
                  $display("FAIL output_event got=%h@%0d required=%h@%0d", cur, cyc, ev, t);
               end
            end
            prev = cur;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int e, c, lvl, sel, k;
      idle_inputs();
      repeat (3) @(negedge clk);
      check("reset_g2_ps_cmd",     int'(bus.g2_ps_cmd), 0);
      check("reset_dr_amp_cmd",    int'(bus.dr_amp_cmd), 0);
      check("reset_an_ps_cmd",     int'(bus.an_ps_cmd), 0);
      check("reset_running",       int'(bus.running), 0);
      check("reset_perm_denied",   int'(bus.perm_denied), 0);
      check("reset_fault_latched", int'(bus.fault_latched), 0);
      check("reset_fault_code",    int'(bus.fault_code), 0);
      check("reset_state",         int'(bus.state_o), int'(ST_IDLE));
      reset = 1'b0;
      prev = pack();
      mon_en = 1'b1;

      // on_req without permits: one-cycle perm_denied pulse, nothing else
      bus.n_on_perm_an = 1'b1;
      push(cyc + 1, mk(0, 0, 0, 0, 1, 0, 3'd0, ST_IDLE));
      push(cyc + 2, mk(0, 0, 0, 0, 0, 0, 3'd0, ST_IDLE));
      pulse(0);
      drain(20);
      bus.n_on_perm_an = 1'b0;
      bus.n_on_perm_drv = 1'b1;
      push(cyc + 1, mk(0, 0, 0, 0, 1, 0, 3'd0, ST_IDLE));
      push(cyc + 2, mk(0, 0, 0, 0, 0, 0, 3'd0, ST_IDLE));
      pulse(0);
      drain(20);
      bus.n_on_perm_drv = 1'b0;

      // off_req and fault_ack in IDLE do nothing
      pulse(1);
      pulse(2);
      drain(10);

      // nominal sequence, stray on_req in RUN, then shutdown
      run_to(4, 10, 5, e);
      at(e + 2);
      pulse(0);
      shutdown(4);

      // exits on the very last cycle before each timeout
      run_to(4, T_G2, T_DRV, e);
      at(e + 1);
      shutdown(4);

      // G2 timeout
      run_to(1, 1, 1, e);
      push(e + T_G2, mk(0, 0, 0, 0, 0, 1, 3'd3, ST_FAULT));
      drain(400);
      recover();

      // driver amp timeout
      run_to(2, $urandom_range(1, T_G2), 1, e);
      push(e + T_DRV, mk(0, 0, 0, 0, 0, 1, 3'd6, ST_FAULT));
      drain(600);
      recover();

      // simultaneous causes, frozen code, refused acknowledge
      run_to(4, 10, 5, e);
      at(e + 3);
      bus.n_on_perm_drv = 1'b1;
      bus.n_dr_amp_ok   = 1'b1;
      push(cyc + 1, mk(0, 0, 0, 0, 0, 1, 3'd2, ST_FAULT));
      drain(200);
      bus.n_on_perm_an = 1'b1;
      bus.n_g2_ok      = 1'b1;
      bus.n_u_g2_low   = 1'b0;
      repeat (10) @(negedge clk);
      pulse(2);
      repeat (5) @(negedge clk);
      check("ack_refused_state", int'(bus.state_o), int'(ST_FAULT));
      check("ack_refused_code",  int'(bus.fault_code), 2);
      recover();

      // randomised fault injection and shutdowns
      for (int it = 0; it < 14; it++) begin
         sel = $urandom_range(0, 2);
         lvl = $urandom_range(1, 4);
         if (sel == 0) begin
            run_to(lvl, $urandom_range(1, T_G2), $urandom_range(1, T_DRV), e);
            at(e + $urandom_range(0, 20));
            shutdown(lvl);
         end else begin
            case (lvl)
               1:       k = $urandom_range(0, 300);
               2:       k = $urandom_range(0, 110);
               3:       k = $urandom_range(0, T_SET - 1);
               default: k = $urandom_range(0, 40);
            endcase
            fault_case(lvl, k, 5'($urandom_range(1, 31)));
         end
      end

      // reset while in AN_START
      run_to(3, $urandom_range(1, T_G2), $urandom_range(1, T_DRV), e);
      at(e + $urandom_range(0, 60));
      reset = 1'b1;
      c = cyc;
      push(c + 1, mk(0, 0, 0, 0, 0, 0, 3'd0, ST_IDLE));
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      drain(50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
